// File: rtl/sha256d_arbiter.sv
// Round-robin arbiter that shares one sha256d engine among NUM_REQ requesters, with an engine watchdog.
// Latency: req_ready at t, eng_start at t+1, rsp_valid one cycle after eng_done or watchdog expiry.
// Backpressure: one transaction in flight; requesters hold req_valid until their one-cycle req_ready pulse.
module sha256d_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*256-1:0] req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic                   rsp_error,
    output logic [255:0]           rsp_hash,
    output logic                   eng_start,
    output logic [255:0]           eng_data,
    input  logic                   eng_done,
    input  logic [255:0]           eng_hash,
    output logic                   busy
);

    localparam int          PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESPOND
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_winner;
    logic [PTR_W-1:0]   w_winner;
    logic               w_found;
    logic [255:0]       w_sel_dat;
    logic [15:0]        r_wd_cnt;
    logic               r_err;
    logic [255:0]       r_msg;
    logic [255:0]       r_hash;
    logic               w_expire;

    // First requesting index at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        logic [PTR_W:0]   v_sum;
        logic [PTR_W-1:0] v_idx;
        w_found  = 1'b0;
        w_winner = '0;
        v_sum    = '0;
        v_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            if (v_sum >= (PTR_W+1)'(NUM_REQ)) begin
                v_sum = v_sum - (PTR_W+1)'(NUM_REQ);
            end
            v_idx = v_sum[PTR_W-1:0];
            if (!w_found && req_valid[v_idx]) begin
                w_found  = 1'b1;
                w_winner = v_idx;
            end
        end
    end

    always_comb begin
        w_sel_dat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == PTR_W'(i)) begin
                w_sel_dat = req_data[i*256 +: 256];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        rsp_valid   = '0;
        rsp_error   = 1'b0;
        eng_start   = 1'b0;
        w_expire    = 1'b0;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                // Gated by reset_n so no grant is shown while reset is held.
                if (w_found && reset_n) begin
                    req_ready[w_winner] = 1'b1;
                    w_state_nxt         = S_ISSUE;
                end
            end
            S_ISSUE: begin
                eng_start   = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A completion on the expiry cycle takes priority over the watchdog.
                if (eng_done) begin
                    w_state_nxt = S_RESPOND;
                end else if (r_wd_cnt == WD_LAST) begin
                    w_expire    = 1'b1;
                    w_state_nxt = S_RESPOND;
                end
            end
            S_RESPOND: begin
                rsp_valid[r_winner] = 1'b1;
                rsp_error           = r_err;
                w_state_nxt         = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= '0;
            r_winner <= '0;
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
            r_msg    <= '0;
            r_hash   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_msg    <= w_sel_dat;
                        r_winner <= w_winner;
                    end
                end
                S_ISSUE: begin
                    r_wd_cnt <= '0;
                end
                S_WAIT: begin
                    r_wd_cnt <= r_wd_cnt + 16'd1;
                    if (eng_done) begin
                        r_hash <= eng_hash;
                        r_err  <= 1'b0;
                    end else if (w_expire) begin
                        r_hash <= '0;
                        r_err  <= 1'b1;
                    end
                end
                S_RESPOND: begin
                    r_rr_ptr <= (r_winner == PTR_W'(NUM_REQ - 1)) ? '0 : r_winner + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign rsp_hash = r_hash;
    assign eng_data = r_msg;

endmodule

// File: tb/tb_sha256d_arbiter.sv
// Self-checking bench for sha256d_arbiter: vector table plus contention, reset-abort and stray-done sequences.
module tb_sha256d_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [N-1:0]     req_valid;
    logic [N*256-1:0] req_data;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     rsp_valid;
    logic             rsp_error;
    logic [255:0]     rsp_hash;
    logic             eng_start;
    logic [255:0]     eng_data;
    logic             eng_done;
    logic [255:0]     eng_hash;
    logic             busy;

    sha256d_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_hash(rsp_hash),
        .eng_start(eng_start), .eng_data(eng_data),
        .eng_done(eng_done), .eng_hash(eng_hash), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] valid; int delay; int win; logic err; } vec_t;
    typedef struct { int win; logic err; logic [255:0] hash; int cyc; } exp_t;

    exp_t         sb[$];
    logic [255:0] msg_q[$];
    vec_t         tbl[10];

    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    int           exp_win = 0;
    logic         exp_err = 1'b0;
    bit           auto_rr = 1'b0;
    int           eng_delay = -1;
    bit           eng_pend = 1'b0;
    int           eng_left = 0;
    logic [255:0] cur_hash = '0;
    bit           stray_done = 1'b0;
    logic         rst_v = 1'b0;
    int           acc_cnt = 0;
    int           rsp_cnt = 0;
    int           last_acc = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic monitor();
        exp_t e;
        if (|req_ready || |rsp_valid) begin
            chk("single_pulse", 256'($countones(req_ready) + $countones(rsp_valid)), 256'(1));
        end
        if (|req_ready) begin
            chk("grant", 256'(req_ready), 256'(4'b0001 << exp_win));
            msg_q.push_back(req_data[exp_win*256 +: 256]);
            cur_hash = rand256();
            e.win  = exp_win;
            e.err  = exp_err;
            e.hash = exp_err ? 256'd0 : cur_hash;
            e.cyc  = cyc + 2 + (exp_err ? TO : eng_delay);
            sb.push_back(e);
            last_acc = cyc;
            acc_cnt++;
            if (auto_rr) exp_win = (exp_win + 1) % N;
        end
        if (eng_start) begin
            chk("start_cycle", 256'(cyc), 256'(last_acc + 1));
            if (msg_q.size() > 0) chk("eng_data", eng_data, msg_q.pop_front());
            else chk("eng_start_unexpected", 256'(eng_start), 256'(0));
            if (eng_delay > 0) begin
                eng_pend = 1'b1;
                eng_left = eng_delay - 1;
            end
        end
        if (|rsp_valid) begin
            rsp_cnt++;
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 256'(rsp_valid), 256'(0));
            end else begin
                e = sb.pop_front();
                chk("rsp_idx", 256'(rsp_valid), 256'(4'b0001 << e.win));
                chk("rsp_err", 256'(rsp_error), 256'(e.err));
                chk("rsp_hash", rsp_hash, e.hash);
                chk("rsp_cycle", 256'(cyc), 256'(e.cyc));
            end
        end
    endtask

    task automatic step(input logic [3:0] v);
        @(posedge clk);
        cyc++;
        #1;
        reset_n   = rst_v;
        req_valid = v;
        for (int i = 0; i < N; i++) req_data[i*256 +: 256] = rand256();
        eng_done  = stray_done;
        eng_hash  = rand256();
        if (eng_pend) begin
            if (eng_left == 0) begin
                eng_done = 1'b1;
                eng_hash = cur_hash;
                eng_pend = 1'b0;
            end else begin
                eng_left--;
            end
        end
        @(negedge clk);
        monitor();
    endtask

    task automatic run_vec(input vec_t r);
        int a0;
        int r0;
        exp_win   = r.win;
        exp_err   = r.err;
        eng_delay = r.delay;
        auto_rr   = 1'b0;
        a0 = acc_cnt;
        r0 = rsp_cnt;
        for (int k = 0; k < 8 && acc_cnt == a0; k++) step(r.valid);
        chk("accepted", 256'(acc_cnt - a0), 256'(1));
        for (int k = 0; k < TO + 10 && rsp_cnt == r0; k++) step(4'b0000);
        chk("responded", 256'(rsp_cnt - r0), 256'(1));
        step(4'b0000);
    endtask

    initial begin
        logic [255:0] held;
        tbl[0] = '{4'b1111,  1, 0, 1'b0};
        tbl[1] = '{4'b0001,  3, 0, 1'b0};
        tbl[2] = '{4'b0001,  1, 0, 1'b0};
        tbl[3] = '{4'b1010,  5, 1, 1'b0};
        tbl[4] = '{4'b1010,  2, 3, 1'b0};
        tbl[5] = '{4'b1100, -1, 2, 1'b1};
        tbl[6] = '{4'b0111, 16, 0, 1'b0};
        tbl[7] = '{4'b0101, 17, 2, 1'b1};
        tbl[8] = '{4'b1001,  4, 3, 1'b0};
        tbl[9] = '{4'b0110,  2, 1, 1'b0};

        reset_n   = 1'b0;
        req_valid = '1;
        req_data  = '0;
        eng_done  = 1'b0;
        eng_hash  = '0;

        // Reset values, with all requesters asserting.
        rst_v = 1'b0;
        step(4'b1111);
        step(4'b1111);
        chk("rst_req_ready", 256'(req_ready), 256'(0));
        chk("rst_rsp_valid", 256'(rsp_valid), 256'(0));
        chk("rst_rsp_error", 256'(rsp_error), 256'(0));
        chk("rst_rsp_hash", rsp_hash, 256'd0);
        chk("rst_eng_start", 256'(eng_start), 256'(0));
        chk("rst_eng_data", eng_data, 256'd0);
        chk("rst_busy", 256'(busy), 256'(0));

        // Contention: 1111 held from reset release, five grants 0,1,2,3,0.
        rst_v     = 1'b1;
        exp_win   = 0;
        exp_err   = 1'b0;
        eng_delay = 2;
        auto_rr   = 1'b1;
        for (int k = 0; k < 200 && acc_cnt < 5; k++) step(4'b1111);
        chk("contention_grants", 256'(acc_cnt), 256'(5));
        for (int k = 0; k < 20 && rsp_cnt < 5; k++) step(4'b0000);
        chk("contention_rsps", 256'(rsp_cnt), 256'(5));
        auto_rr = 1'b0;
        step(4'b0000);

        // Reset two cycles after eng_start; late eng_done after release.
        exp_win   = 1;
        exp_err   = 1'b0;
        eng_delay = 6;
        step(4'b0010);
        chk("abort_accept", 256'(acc_cnt), 256'(6));
        step(4'b0000);
        chk("abort_start", 256'(eng_start), 256'(1));
        step(4'b0000);
        rst_v = 1'b0;
        step(4'b0000);
        step(4'b0000);
        chk("abort_busy_in_rst", 256'(busy), 256'(0));
        chk("abort_hash_in_rst", rsp_hash, 256'd0);
        sb.delete();
        msg_q.delete();
        rst_v = 1'b1;
        for (int k = 0; k < 8; k++) step(4'b0000);
        chk("abort_no_rsp", 256'(rsp_cnt), 256'(5));
        chk("abort_busy", 256'(busy), 256'(0));
        chk("abort_engine_done_seen", 256'(eng_pend), 256'(0));

        // Table: first entry shows rr_ptr was cleared by the reset.
        for (int i = 0; i < 10; i++) run_vec(tbl[i]);

        // Stray eng_done while idle.
        held = rsp_hash;
        stray_done = 1'b1;
        step(4'b0000);
        stray_done = 1'b0;
        chk("stray_pulses", 256'({req_ready, rsp_valid, eng_start}), 256'(0));
        step(4'b0000);
        chk("stray_hash", rsp_hash, held);
        chk("stray_busy", 256'(busy), 256'(0));
        chk("sb_drained", 256'(sb.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sha256d_arbiter.md
SHA256D_ARBITER -- requirements
Module: sha256d_arbiter

Interface

Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters sharing one sha256d engine; legal range 2..8.
REQ-002 The block SHALL have parameter TIMEOUT, default 1024: engine watchdog limit in clock cycles; legal range 16..65535.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port req_valid, input, NUM_REQ: per-requester hash request.
REQ-006 The block SHALL have port req_data, input, NUM_REQ*256: per-requester 256-bit message; slice i is [256*i+255 : 256*i].
REQ-007 The block SHALL have port req_ready, output, NUM_REQ: one-cycle accept pulse; req_data of that requester is captured on that same edge.
REQ-008 The block SHALL have port rsp_valid, output, NUM_REQ: one-cycle completion pulse to the served requester.
REQ-009 The block SHALL have port rsp_error, output, 1: qualifies rsp_valid; 1 = watchdog expiry, and rsp_hash is then 0.
REQ-010 The block SHALL have port rsp_hash, output, 256: result, shared by all requesters, held stable until the next RESPOND.
REQ-011 The block SHALL have port eng_start, output, 1: one-cycle start pulse to the sha256d engine.
REQ-012 The block SHALL have port eng_data, output, 256: message to the engine, held stable from eng_start until the engine completes or the watchdog expires.
REQ-013 The block SHALL have port eng_done, input, 1: one-cycle pulse from the engine; eng_hash is valid in that cycle.
REQ-014 The block SHALL have port eng_hash, input, 256: double-SHA256 result from the engine.
REQ-015 The block SHALL have port busy, output, 1: high in every state except IDLE.

Function

REQ-016 The block SHALL implement a four-state FSM: IDLE, ISSUE, WAIT, RESPOND.
REQ-017 In IDLE with any req_valid bit set, the block SHALL select winner = the first set bit scanning upward from rr_ptr with wrap-around, pulse req_ready[winner], capture its req_data and index, and move to ISSUE.
REQ-018 In IDLE with req_valid all zero, the block SHALL remain in IDLE with all pulse outputs low.
REQ-019 In ISSUE, the block SHALL drive eng_start high for exactly one cycle, drive eng_data from the captured message, clear the watchdog counter, and move to WAIT.
REQ-020 In WAIT, the block SHALL increment the watchdog counter each cycle.
REQ-021 In WAIT, on eng_done the block SHALL latch eng_hash into rsp_hash, clear the error flag, and move to RESPOND.
REQ-022 In WAIT, when the counter reaches TIMEOUT-1 without eng_done, the block SHALL set rsp_hash to 0, set the error flag, and move to RESPOND.
REQ-023 If eng_done and watchdog expiry occur in the same cycle, eng_done SHALL win and no error SHALL be flagged.
REQ-024 In RESPOND, the block SHALL pulse rsp_valid[winner] for one cycle with rsp_error equal to the error flag, set rr_ptr to (winner+1) mod NUM_REQ, and return to IDLE.
REQ-025 eng_done SHALL be ignored outside WAIT.
REQ-026 req_valid and req_data changes after acceptance SHALL have no effect on the transaction in flight.
REQ-027 Latency SHALL be: req_ready at cycle t, eng_start at t+1, and rsp_valid exactly one cycle after the eng_done cycle (or after the expiry cycle).
REQ-028 A requester holding req_valid continuously SHALL be re-served no earlier than after every other active requester has been served once (starvation-free).
REQ-029 At most one bit of req_ready and at most one bit of rsp_valid SHALL be high in any cycle; req_ready and rsp_valid SHALL never be high in the same cycle.

Reset

REQ-030 While reset_n is low, the block SHALL hold state IDLE, rr_ptr 0, watchdog counter 0, error flag 0, req_ready 0, rsp_valid 0, rsp_error 0, rsp_hash 0, eng_start 0, eng_data 0 and busy 0.
REQ-031 Reset asserted mid-transaction SHALL abort it with no rsp_valid pulse, and a late eng_done after release SHALL be ignored per REQ-025.

Verification

REQ-032 Single request: engine model returns eng_done 3 cycles after eng_start with eng_hash=256'hAA..AA; req_valid=4'b0001 at cycle 0 -> req_ready=0001 at 0, eng_start at 1, eng_done at 4, rsp_valid=0001 at 5, rsp_error=0, rsp_hash=AA..AA.
REQ-033 Contention: req_valid=4'b1111 held continuously from reset -> grants in order 0,1,2,3,0 with one rsp_valid per grant and no overlap.
REQ-034 Watchdog: engine never returns eng_done, TIMEOUT=16 -> rsp_valid at eng_start+17, rsp_error=1, rsp_hash=0; next request is served normally.
REQ-035 Simultaneous events: eng_done lands exactly on the expiry cycle -> rsp_error=0 and rsp_hash=eng_hash.
REQ-036 Reset mid-WAIT: drop reset_n 2 cycles after eng_start, release, then pulse eng_done -> no rsp_valid, busy=0, rr_ptr=0.
REQ-037 Stray eng_done in IDLE with req_valid=0 -> no output pulse and rsp_hash unchanged.
